// File: rtl/osch_emul.sv
// osch_emul: synthesizable stand-in for an on-chip oscillator primitive.
// A phase accumulator clocked by the fast reference clock produces a slow,
// registered, glitch-free clock OSC, with standby control and status.
// Optional build macro: OSCH_READY_EN adds a READY output that is high only
// while the accumulator is actually advancing.
module osch_emul #(
    parameter int NOM_FREQ_KHZ = 2080,
    parameter int REF_FREQ_KHZ = 100000,
    parameter int ACC_W        = 24,
    parameter int START_CYCLES = 16
) (
    input  logic clk,
    input  logic RESET,
    input  logic STDBY,
    output logic OSC,
    output logic SEDSTDBY
`ifdef OSCH_READY_EN
    ,
    output logic READY
`endif
);

    // Phase increment, rounded to nearest, clamped so OSC never exceeds clk/2.
    localparam logic [63:0] SCALE       = 64'd1 << ACC_W;
    localparam logic [63:0] INC_RAW     = (64'(NOM_FREQ_KHZ) * SCALE + 64'(REF_FREQ_KHZ / 2))
                                          / 64'(REF_FREQ_KHZ);
    localparam logic [63:0] INC_MAX     = 64'd1 << (ACC_W - 1);
    localparam logic [63:0] INC_CLAMPED = (INC_RAW >= INC_MAX) ? INC_MAX : INC_RAW;
    localparam logic [ACC_W-1:0] INC    = INC_CLAMPED[ACC_W-1:0];

    // Startup counter sized to hold START_CYCLES.
    localparam int CNT_W = (START_CYCLES < 1) ? 1 : $clog2(START_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_CYCLES);

    // A zero increment would freeze OSC forever; refuse to build it.
    generate
        if (INC_RAW == 64'd0) begin : g_inc_zero
            $error("osch_emul: phase increment rounds to zero, NOM_FREQ_KHZ too low for ACC_W");
        end
    endgenerate

    // ST_START: startup delay counting down (OSC held low, acc held at 0)
    // ST_RUN  : accumulator advancing every cycle
    // ST_STDBY: stopped by standby request
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_STDBY = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [ACC_W-1:0] acc_reg,   acc_next;
    logic             osc_reg,   osc_next;
    logic [ACC_W-1:0] acc_sum;

    // State register: synchronous active-low reset restarts the startup delay.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_reg <= ST_START;
            cnt_reg   <= CNT_LOAD;
            acc_reg   <= '0;
            osc_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            osc_reg   <= osc_next;
        end
    end

    // Next-state logic: standby wins over everything except reset; OSC follows
    // the MSB of the accumulator value being written, so it lags acc by nothing
    // and stays a clean registered signal.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        osc_next   = osc_reg;
        acc_sum    = acc_reg + INC;

        if (STDBY) begin
            // Entering or holding standby truncates any high phase.
            state_next = ST_STDBY;
            cnt_next   = CNT_LOAD;
            acc_next   = '0;
            osc_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_STDBY: begin
                    // Leaving standby: full startup delay again, from phase 0.
                    state_next = ST_START;
                    cnt_next   = CNT_LOAD;
                    acc_next   = '0;
                    osc_next   = 1'b0;
                end
                ST_START: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end else begin
                        state_next = ST_RUN;
                        acc_next   = acc_sum;
                        osc_next   = acc_sum[ACC_W-1];
                    end
                end
                ST_RUN: begin
                    acc_next = acc_sum;
                    osc_next = acc_sum[ACC_W-1];
                end
                default: begin
                    state_next = ST_START;
                    cnt_next   = CNT_LOAD;
                    acc_next   = '0;
                    osc_next   = 1'b0;
                end
            endcase
        end
    end

    assign OSC      = osc_reg;
    assign SEDSTDBY = (state_reg == ST_STDBY);

`ifdef OSCH_READY_EN
    // ST_RUN is entered on the very edge of the first accumulator increment.
    assign READY = (state_reg == ST_RUN);
`endif

endmodule

// File: tb/tb_osch_emul.sv
// tb_osch_emul: three osch_emul instances (exact clk/8, default 2.08 MHz,
// clamped clk/2) share clock, reset and standby. A reference model tracks,
// per instance, the number of increments since running began and derives
// OSC as the MSB of (count * increment) mod 2^ACC_W.
module tb_osch_emul;

    localparam int W     = 24;
    localparam int S     = 16;
    localparam int REF   = 100000;
    localparam int NDUT  = 3;
    localparam int NOM_A = 12500;
    localparam int NOM_D = 2080;
    localparam int NOM_C = 80000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stdby = 1'b0;
    logic [NDUT-1:0] osc;
    logic [NDUT-1:0] sed;
`ifdef OSCH_READY_EN
    logic [NDUT-1:0] rdy;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    longint unsigned inc_tab [NDUT];
    bit              m_sed   [NDUT];
    int              m_cnt   [NDUT];
    longint unsigned m_n     [NDUT];
    bit              m_osc   [NDUT];
    bit              m_rdy   [NDUT];

    always #5 clk = ~clk;

    osch_emul #(.NOM_FREQ_KHZ(NOM_A), .REF_FREQ_KHZ(REF), .ACC_W(W), .START_CYCLES(S)) dut_a (
        .clk(clk), .RESET(rst_n), .STDBY(stdby), .OSC(osc[0]), .SEDSTDBY(sed[0])
`ifdef OSCH_READY_EN
        , .READY(rdy[0])
`endif
    );
    osch_emul #(.NOM_FREQ_KHZ(NOM_D), .REF_FREQ_KHZ(REF), .ACC_W(W), .START_CYCLES(S)) dut_d (
        .clk(clk), .RESET(rst_n), .STDBY(stdby), .OSC(osc[1]), .SEDSTDBY(sed[1])
`ifdef OSCH_READY_EN
        , .READY(rdy[1])
`endif
    );
    osch_emul #(.NOM_FREQ_KHZ(NOM_C), .REF_FREQ_KHZ(REF), .ACC_W(W), .START_CYCLES(S)) dut_c (
        .clk(clk), .RESET(rst_n), .STDBY(stdby), .OSC(osc[2]), .SEDSTDBY(sed[2])
`ifdef OSCH_READY_EN
        , .READY(rdy[2])
`endif
    );

    function automatic longint unsigned calc_inc(longint unsigned nom);
        longint unsigned raw, half;
        raw  = (nom * (64'd1 << W) + longint'(REF / 2)) / longint'(REF);
        half = 64'd1 << (W - 1);
        return (raw >= half) ? half : raw;
    endfunction

    // Advance one clock: apply the spec rules to the model using the inputs
    // the DUT sees at this edge, then return on the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                m_sed[i] = 0; m_cnt[i] = S; m_n[i] = 0; m_osc[i] = 0; m_rdy[i] = 0;
            end else if (stdby) begin
                m_sed[i] = 1; m_cnt[i] = S; m_n[i] = 0; m_osc[i] = 0; m_rdy[i] = 0;
            end else if (m_sed[i]) begin
                m_sed[i] = 0; m_cnt[i] = S;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
            end else begin
                m_n[i]   = m_n[i] + 1;
                m_osc[i] = (((m_n[i] * inc_tab[i]) % (64'd1 << W)) >> (W - 1)) != 0;
                m_rdy[i] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        longint unsigned half;
        int k, exp_rise, h, l;
        half = 64'd1 << (W - 1);
        rst_n = 1'b0;
        stdby = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (osc !== '0 || sed !== '0) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: osc=%b sed=%b want 000/000", c, osc, sed);
            end
        end
        rst_n = 1'b1;
        for (k = 1; k <= S; k++) begin
            tick();
            n_cmp++;
            if (osc !== '0 || sed !== '0) begin
                n_bad++;
                $display("FAIL startup_low k=%0d: osc=%b sed=%b want 000/000", k, osc, sed);
            end
`ifdef OSCH_READY_EN
            n_cmp++;
            if (rdy !== '0) begin
                n_bad++;
                $display("FAIL ready_startup k=%0d: got %b want 000", k, rdy);
            end
`endif
        end
        k = S;
        do begin
            tick();
            k++;
`ifdef OSCH_READY_EN
            if (k == S + 1) begin
                n_cmp++;
                if (rdy !== '1) begin
                    n_bad++;
                    $display("FAIL ready_rise k=%0d: got %b want 111", k, rdy);
                end
            end
`endif
        end while (osc[0] !== 1'b1 && k < 60);
        exp_rise = S + int'((half + inc_tab[0] - 1) / inc_tab[0]);
        n_cmp++;
        if (k != exp_rise) begin
            n_bad++;
            $display("FAIL first_rise: at cycle %0d want %0d", k, exp_rise);
        end
        h = 0;
        while (osc[0] === 1'b1 && h < 50) begin tick(); h++; end
        l = 0;
        while (osc[0] === 1'b0 && l < 50) begin tick(); l++; end
        n_cmp++;
        if (h != int'(half / inc_tab[0])) begin
            n_bad++;
            $display("FAIL high_phase: got %0d want %0d", h, half / inc_tab[0]);
        end
        n_cmp++;
        if (l != int'(half / inc_tab[0])) begin
            n_bad++;
            $display("FAIL low_phase: got %0d want %0d", l, half / inc_tab[0]);
        end
        n_cmp++;
        if (h + l != int'((64'd1 << W) / inc_tab[0])) begin
            n_bad++;
            $display("FAIL period: got %0d want %0d", h + l, (64'd1 << W) / inc_tab[0]);
        end
    endtask

    task automatic test_default_freq();
        longint unsigned half;
        int k, rises, total, run_len, exp_total, ph_nom;
        logic prev;
        half      = 64'd1 << (W - 1);
        exp_total = int'((64'd1000 << W) / inc_tab[1]);
        ph_nom    = int'((half + inc_tab[1] / 2) / inc_tab[1]);
        k = 0;
        while (osc[1] !== 1'b0 && k < 100) begin tick(); k++; end
        while (osc[1] !== 1'b1 && k < 200) begin tick(); k++; end
        rises = 0; total = 0; run_len = 0; prev = osc[1];
        while (rises < 1000 && total < 60000) begin
            tick();
            total++;
            run_len++;
            if (osc[1] !== prev) begin
                n_cmp++;
                if (run_len < ph_nom - 1 || run_len > ph_nom + 1) begin
                    n_bad++;
                    $display("FAIL phase_len lvl=%b: got %0d want %0d+-1", prev, run_len, ph_nom);
                end
                if (osc[1] === 1'b1) rises++;
                run_len = 0;
                prev = osc[1];
            end
        end
        n_cmp++;
        if (rises != 1000 || total < exp_total - 1 || total > exp_total + 1) begin
            n_bad++;
            $display("FAIL period_1000: %0d cycles for %0d rises want %0d+-1 for 1000",
                     total, rises, exp_total);
        end
    endtask

    task automatic test_standby();
        longint unsigned half;
        int k, exp_rise;
        half = 64'd1 << (W - 1);
        k = 0;
        while (osc[0] !== 1'b1 && k < 40) begin tick(); k++; end
        tick();
        n_cmp++;
        if (osc[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_midhigh: osc=%b want 1", osc[0]);
        end
        stdby = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            n_cmp++;
            if (osc !== '0 || sed !== '1) begin
                n_bad++;
                $display("FAIL sb_hold cyc %0d: osc=%b sed=%b want 000/111", c, osc, sed);
            end
`ifdef OSCH_READY_EN
            n_cmp++;
            if (rdy !== '0) begin
                n_bad++;
                $display("FAIL ready_sb cyc %0d: got %b want 000", c, rdy);
            end
`endif
        end
        stdby = 1'b0;
        tick();
        n_cmp++;
        if (sed !== '0 || osc !== '0) begin
            n_bad++;
            $display("FAIL sb_exit: osc=%b sed=%b want 000/000", osc, sed);
        end
        k = 1;
        while (osc[0] !== 1'b1 && k < 60) begin tick(); k++; end
        exp_rise = 1 + S + int'((half + inc_tab[0] - 1) / inc_tab[0]);
        n_cmp++;
        if (k != exp_rise) begin
            n_bad++;
            $display("FAIL sb_first_rise: at cycle %0d want %0d", k, exp_rise);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (osc[i] !== m_osc[i] || sed[i] !== m_sed[i]) begin
                    n_bad++;
                    $display("FAIL sb_resume dut%0d: osc=%b sed=%b want %b/%b",
                             i, osc[i], sed[i], m_osc[i], m_sed[i]);
                end
            end
        end
    endtask

    task automatic test_reset_in_standby();
        stdby = 1'b1;
        tick();
        n_cmp++;
        if (sed !== '1) begin
            n_bad++;
            $display("FAIL rs_enter: sed=%b want 111", sed);
        end
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (sed !== '0 || osc !== '0) begin
                n_bad++;
                $display("FAIL rs_reset cyc %0d: osc=%b sed=%b want 000/000", c, osc, sed);
            end
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (sed !== '1 || osc !== '0) begin
            n_bad++;
            $display("FAIL rs_release: osc=%b sed=%b want 000/111", osc, sed);
        end
        stdby = 1'b0;
        tick();
        n_cmp++;
        if (sed !== '0) begin
            n_bad++;
            $display("FAIL rs_exit: sed=%b want 000", sed);
        end
    endtask

    task automatic test_clamp();
        int k;
        logic prev;
        k = 0;
        while (osc[2] !== 1'b1 && k < 40) begin tick(); k++; end
        n_cmp++;
        if (k != S + 1) begin
            n_bad++;
            $display("FAIL clamp_first_rise: at cycle %0d want %0d", k, S + 1);
        end
        for (int c = 0; c < 20; c++) begin
            prev = osc[2];
            tick();
            n_cmp++;
            if (osc[2] !== ~prev) begin
                n_bad++;
                $display("FAIL clamp_toggle cyc %0d: got %b want %b", c, osc[2], ~prev);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) stdby = ~stdby;
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (osc[i] !== m_osc[i] || sed[i] !== m_sed[i]) begin
                    n_bad++;
                    $display("FAIL rnd dut%0d cyc %0d: osc=%b sed=%b want %b/%b",
                             i, c, osc[i], sed[i], m_osc[i], m_sed[i]);
                end
`ifdef OSCH_READY_EN
                n_cmp++;
                if (rdy[i] !== m_rdy[i]) begin
                    n_bad++;
                    $display("FAIL rnd_ready dut%0d cyc %0d: got %b want %b", i, c, rdy[i], m_rdy[i]);
                end
`endif
            end
        end
        rst_n = 1'b1;
        stdby = 1'b0;
    endtask

    initial begin
        inc_tab[0] = calc_inc(NOM_A);
        inc_tab[1] = calc_inc(NOM_D);
        inc_tab[2] = calc_inc(NOM_C);
        for (int i = 0; i < NDUT; i++) begin
            m_sed[i] = 0; m_cnt[i] = S; m_n[i] = 0; m_osc[i] = 0; m_rdy[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_default_freq();
        test_standby();
        test_reset_in_standby();
        test_clamp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
